// File: rtl/fxp_uart_tx.sv
// Serialises one n-bit fixed-point word as n/8 8N1 bytes, MSB byte first, LSB bit first.
// One-cycle accept-to-start-bit latency; ready only in IDLE, valid ignored while busy.
module fxp_uart_tx #(
  parameter int n            = 32,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [n-1:0] data,
  output logic         ready,
  output logic         tx,
  output logic         busy,
  output logic         done
);

  localparam int NB = n / 8;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [2:0]     bit_idx, bit_nxt;
  logic [BW-1:0]  byte_idx, byte_nxt;
  logic [n-1:0]   shreg, shreg_nxt;
  logic           tx_nxt, done_nxt;
  logic           bit_end;
  logic [7:0]     cur_byte;

  assign bit_end = (cnt == CNT_LAST);
  assign ready   = (state == IDLE);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    byte_nxt  = byte_idx;
    shreg_nxt = shreg;
    done_nxt  = 1'b0;

    unique case (state)
      IDLE: begin
        if (valid) begin
          state_nxt = START;
          shreg_nxt = data;
          cnt_nxt   = '0;
          bit_nxt   = '0;
          byte_nxt  = '0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nxt   = '0;
          bit_nxt   = '0;
          state_nxt = DATA;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            bit_nxt   = '0;
            state_nxt = STOP;
          end else begin
            bit_nxt = bit_idx + 1'b1;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (byte_idx == BYTE_LAST) begin
            byte_nxt  = '0;
            shreg_nxt = '0;
            done_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            // next byte moves into the top 8 bits with no idle gap
            byte_nxt  = byte_idx + 1'b1;
            shreg_nxt = shreg << 8;
            state_nxt = START;
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx is computed from the next state so the line register changes with the FSM
    cur_byte = shreg_nxt[n-1 -: 8];
    unique case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = cur_byte[bit_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      bit_idx  <= bit_nxt;
      byte_idx <= byte_nxt;
      shreg    <= shreg_nxt;
      tx       <= tx_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_fxp_uart_tx.sv
// Bench for fxp_uart_tx: cycle-accurate queue model of the expected line plus literal frame pins.
module tb_fxp_uart_tx;
  localparam int N    = 32;
  localparam int CPB  = 4;
  localparam int WORD = (N / 8) * 10 * CPB;

  logic         clk = 1'b0;
  logic         rst, valid;
  logic [N-1:0] data;
  logic         ready, tx, busy, done;

  always #5 clk = ~clk;

  fxp_uart_tx #(.n(N), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .valid(valid), .data(data),
    .ready(ready), .tx(tx), .busy(busy), .done(done)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: queue of line levels for the cycles of the frame still to come.
  bit mq[$];
  bit exp_done = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      exp_done = 1'b0;
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
      exp_done = (mq.size() == 0);
    end else begin
      exp_done = 1'b0;
      if (valid) begin
        for (int b = 0; b < N / 8; b++) begin
          logic [7:0] by;
          by = data[N-1-8*b -: 8];
          for (int c = 0; c < CPB; c++) mq.push_back(1'b0);
          for (int i = 0; i < 8; i++)
            for (int c = 0; c < CPB; c++) mq.push_back(by[i]);
          for (int c = 0; c < CPB; c++) mq.push_back(1'b1);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic idle;
    idle = (mq.size() == 0);
    check("tx",    64'(tx),    idle ? 64'd1 : 64'(mq[0]));
    check("ready", 64'(ready), 64'(idle));
    check("busy",  64'(busy),  64'(!idle));
    check("done",  64'(done),  64'(exp_done));
  end

  // Per-cycle capture relative to the accept edge (index k = k-th cycle after accept).
  logic cap [0:399];
  logic rdy [0:399];
  logic dn  [0:399];

  task automatic start(input logic [N-1:0] w);
    @(negedge clk);
    valid = 1'b1;
    data  = w;
  endtask

  task automatic run(input int ncyc, input bit hold, input int hold_until,
                     input int pulse_at, input int rst_at, input logic [N-1:0] data_after);
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      cap[k] = tx;
      rdy[k] = ready;
      dn[k]  = done;
      if (k == 1) data = data_after;
      valid = hold ? (k < hold_until) : (k == pulse_at);
      rst   = (k == rst_at);
    end
    valid = 1'b0;
    rst   = 1'b0;
  endtask

  function automatic int first_done(input int from, input int upto);
    for (int k = from; k <= upto; k++) if (dn[k] === 1'b1) return k;
    return -1;
  endfunction

  function automatic logic [7:0] dec(input int base, input int b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = cap[base + 1 + b * 10 * CPB + (i + 1) * CPB + CPB / 2];
    return r;
  endfunction

  initial begin
    logic [9:0]   pat;
    logic [7:0]   e28 [4];
    logic [N-1:0] w;
    int           cnt;

    // reset held with valid high: nothing may start
    rst = 1'b1; valid = 1'b1; data = $urandom;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_tx", 64'(tx), 64'd1);
      check("rst_ready", 64'(ready), 64'd1);
      check("rst_done", 64'(done), 64'd0);
    end
    rst = 1'b0; valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle_tx", 64'(tx), 64'd1);

    // +1.0: second byte 0x10 bit stream and done timing
    start(32'h00100000);
    run(180, 1'b0, 0, 0, 0, 32'h00100000);
    check("p1_done_cycle", 64'(first_done(1, 180)), 64'd161);
    pat = 10'b1000100000;
    for (int j = 0; j < 10; j++)
      check("p1_byte1_bit", 64'(cap[1 + 10 * CPB + CPB * j + 1]), 64'(pat[j]));

    // -1.0 with data changed right after accept
    e28 = '{8'hFF, 8'hF0, 8'h00, 8'h00};
    start(32'hFFF00000);
    run(180, 1'b0, 0, 0, 0, 32'h12345678);
    for (int b = 0; b < 4; b++) check("m1_byte", 64'(dec(0, b)), 64'(e28[b]));
    check("m1_done_cycle", 64'(first_done(1, 180)), 64'd161);

    // back-to-back with valid held high
    start(32'hA5A5A5A5);
    run(340, 1'b1, 162, 0, 0, 32'h5A5A5A5A);
    check("b2b_done1", 64'(first_done(1, 340)), 64'd161);
    check("b2b_done2", 64'(first_done(162, 340)), 64'd322);
    check("b2b_gap_high", 64'(cap[161]), 64'd1);
    check("b2b_start2", 64'(cap[162]), 64'd0);
    cnt = 0;
    for (int k = 1; k <= 321; k++) if (rdy[k] === 1'b1) cnt++;
    check("b2b_idle_cycles", 64'(cnt), 64'd1);
    for (int b = 0; b < 4; b++) begin
      check("b2b_w1_byte", 64'(dec(0, b)), 64'h00000000000000A5);
      check("b2b_w2_byte", 64'(dec(161, b)), 64'h000000000000005A);
    end

    // reset during 3rd data bit of the second byte
    start(32'h12345678);
    run(120, 1'b0, 0, 0, 54, 32'h0);
    check("abort_tx", 64'(cap[55]), 64'd1);
    check("abort_ready", 64'(rdy[55]), 64'd1);
    check("abort_no_done", 64'(first_done(1, 120)), -64'sd1);
    w = $urandom;
    start(w);
    run(180, 1'b0, 0, 0, 0, $urandom);
    check("abort_next_done", 64'(first_done(1, 180)), 64'd161);
    for (int b = 0; b < 4; b++) check("abort_next_byte", 64'(dec(0, b)), 64'(w[N-1-8*b -: 8]));

    // valid pulse while busy, then randomized words with random gaps and pulses
    for (int r = 0; r < 7; r++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = (r == 0) ? 32'hC3000081 : $urandom;
      start(w);
      run(180, 1'b0, 0, (r == 0) ? 20 : $urandom_range(2, 158), 0, $urandom);
      check("rand_done", 64'(first_done(1, 180)), 64'd161);
      for (int b = 0; b < 4; b++) check("rand_byte", 64'(dec(0, b)), 64'(w[N-1-8*b -: 8]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/fxp_uart_tx.md
FXP_UART_TX -- requirements
Module: fxp_uart_tx

Interface
REQ-001 Parameter n, default 32: word width; fixed-point Q format of 1 sign bit, 11 integer bits and 20 fraction bits; must be a multiple of 8.
REQ-002 Parameter CLKS_PER_BIT, default 434: clock cycles per serial bit (50 MHz / 115200 baud); must be ≥ 2.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 valid  input  1  data holds a word to transmit.
REQ-006 data  input  n  fixed-point word to be read out, typically a state register's q.
REQ-007 ready  output  1  block is idle and accepts a word this cycle.
REQ-008 tx  output  1  serial line, 8N1 framing, idle high.
REQ-009 busy  output  1  a frame sequence is in progress.
REQ-010 done  output  1  one-cycle pulse after the last stop bit of a word completes.

Function
REQ-011 The block SHALL accept a word when valid=1 and ready=1 on the same rising edge, capturing data into an internal shift register; later changes on data SHALL have no effect.
REQ-012 ready SHALL be 1 only in IDLE; valid while not in IDLE SHALL be ignored and not queued.
REQ-013 The word SHALL be sent as n/8 bytes, most significant byte first; bits within a byte SHALL be sent LSB first.
REQ-014 Each byte SHALL be framed as 1 start bit (0), 8 data bits, and 1 stop bit (1); each bit SHALL last exactly CLKS_PER_BIT cycles.
REQ-015 There SHALL be no idle gap between consecutive bytes of one word; a word SHALL occupy exactly (n/8)*10*CLKS_PER_BIT cycles.
REQ-016 The FSM SHALL have the states IDLE, START, DATA, STOP, with these transitions:
- IDLE->START on accept
- START->DATA after CLKS_PER_BIT cycles
- DATA->STOP after the 8th bit period
- STOP->START if bytes remain, else STOP->IDLE
REQ-017 tx SHALL go low on the first cycle after the accept edge, giving 1 cycle of latency from accept to the start bit.
REQ-018 A bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap, a bit index SHALL count 0..7, and a byte index SHALL count 0..n/8-1; none SHALL overflow or skip.
REQ-019 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE; busy and ready SHALL be complements at all times.
REQ-020 done SHALL be 1 for exactly one cycle, the first IDLE cycle after the final STOP; in that same cycle ready=1.
REQ-021 An accept in the done cycle SHALL be legal, so back-to-back words are separated only by the 1-cycle IDLE.
REQ-022 tx SHALL be driven from a register and be glitch-free; it SHALL be 1 whenever in IDLE.

Reset
REQ-023 On a rising edge with rst=1, the block SHALL enter IDLE with tx=1, ready=1, busy=0, done=0, and all counters and the shift register at 0.
REQ-024 rst SHALL take priority over valid on the same edge; the word SHALL not be accepted.
REQ-025 rst asserted mid-frame SHALL abort the word; tx SHALL be 1 from the next cycle, and no done pulse SHALL be generated for the aborted word.

Verification (CLKS_PER_BIT=4, n=32)
REQ-026 Scenario: hold rst=1 for 3 cycles with valid=1 -> tx=1, ready=1, busy=0, done=0 throughout, and no frame starts.
REQ-027 Scenario: accept 32'h00100000 (+1.0) -> bytes 00,10,00,00 on tx; byte 2 bit stream is 0,0,0,0,0,1,0,0,0,1 (4 cycles each); done is high on cycle 161 after accept.
REQ-028 Scenario: accept 32'hFFF00000 (-1.0), then change data on the next cycle -> bytes FF,F0,00,00 are sent, unaffected by the change.
REQ-029 Scenario: valid held high continuously with 32'hA5A5A5A5 then 32'h5A5A5A5A -> the second word is accepted on the done cycle, and the frames are separated by exactly one idle-high cycle.
REQ-030 Scenario: assert rst during the 3rd data bit of byte 1 -> tx=1 on the next cycle, ready=1, no done pulse, and a subsequent word is transmitted correctly.
REQ-031 Scenario: pulse valid while busy=1 -> the pulse is ignored; the frame count and bit stream are unchanged.
